lsu_info_ram_writer: RTL and testbench

- Producer side of the InfoRam → LSUOutUnit interface. Accepts warp-wide load/store issue packets from the LSU issue stage and buffers them in a small queue (the info RAM).
- Presents one packet at a time on InfoRamInfo_o/InfoRamAddr_o/InfoRamData_o with a one-cycle RAM_Out strobe.
- Paced by LSUOut_working and stall_i so LSUOutUnit never receives a packet while busy.

---
 rtl/lsu_info_ram_writer_pkg.sv | 30 +++
 rtl/lsu_info_ram_writer_fifo.sv | 56 +++++
 rtl/lsu_info_ram_writer.sv | 111 +++++++++++
 tb/tb_lsu_info_ram_writer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_info_ram_writer_pkg.sv
// Shared types and constants for the LSU info RAM writer: op encodings,
// packet layout and the launch FSM states.
package lsu_info_ram_writer_pkg;

  localparam int SIZE_CORE = 32;
  localparam int LANE_W    = 32;
  localparam int INFO_W    = 42;
  localparam int VEC_W     = SIZE_CORE * LANE_W;
  localparam int ENTRY_W   = INFO_W + 2 * VEC_W;

  localparam logic [2:0] LSU_OP_STORE = 3'b101;
  localparam logic [2:0] LSU_OP_LOAD  = 3'b110;

  typedef struct packed {
    logic [INFO_W-1:0] info;
    logic [VEC_W-1:0]  addr;
    logic [VEC_W-1:0]  data;
  } lsu_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } lsu_state_t;

  function automatic logic lsu_op_supported(input logic [2:0] op);
    return (op == LSU_OP_STORE) || (op == LSU_OP_LOAD);
  endfunction

endpackage

// File: rtl/lsu_info_ram_writer_fifo.sv
// Register-based FIFO holding full issue packets; pointers wrap modulo DEPTH
// and the head entry is always visible on head_o.
module lsu_info_fifo
  import lsu_info_ram_writer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  lsu_entry_t       entry_i,
  input  logic             pop_i,
  output lsu_entry_t       head_o,
  output logic [CNT_W-1:0] count_o
);

  lsu_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/lsu_info_ram_writer.sv
// Queues LSU issue packets and presents them one at a time to LSUOutUnit,
// pacing launches on LSUOut_working with a timeout on the busy handshake.
module lsu_info_ram_writer
  import lsu_info_ram_writer_pkg::*;
#(
  parameter  int DEPTH       = 4,
  parameter  int ACK_TIMEOUT = 15,
  localparam int CNT_W       = $clog2(DEPTH) + 1,
  localparam int TMO_W       = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [31:0]       issue_mask_i,
  input  logic [1:0]        issue_warp_i,
  input  logic [4:0]        issue_reg_i,
  input  logic [2:0]        issue_op_i,
  input  logic [VEC_W-1:0]  issue_addr_i,
  input  logic [VEC_W-1:0]  issue_data_i,
  input  logic              LSUOut_working,
  output logic              RAM_Out,
  output logic [INFO_W-1:0] InfoRamInfo_o,
  output logic [VEC_W-1:0]  InfoRamAddr_o,
  output logic [VEC_W-1:0]  InfoRamData_o,
  output logic [CNT_W-1:0]  queue_count_o,
  output logic              drop_o
);

  lsu_state_t        state_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              ram_out_q, drop_q, drop_d;
  logic [INFO_W-1:0] info_q;
  logic [VEC_W-1:0]  addr_q, data_q;
  logic [CNT_W-1:0]  count;
  logic              push_req, pkt_ok, pop;
  lsu_entry_t        entry_in, head;

  assign issue_ready_o = (count != CNT_W'(DEPTH));
  assign push_req      = issue_valid_i && issue_ready_o;
  assign pkt_ok        = (issue_mask_i != '0) && lsu_op_supported(issue_op_i);
  assign drop_d        = push_req && !pkt_ok;

  // Loads carry no store data; zero it on entry so the output never leaks it.
  assign entry_in.info = {issue_mask_i, issue_warp_i, issue_reg_i, issue_op_i};
  assign entry_in.addr = issue_addr_i;
  assign entry_in.data = (issue_op_i == LSU_OP_LOAD) ? '0 : issue_data_i;

  assign pop = (state_q == ST_IDLE) && (count != '0) && !stall_i && !LSUOut_working;

  lsu_info_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req && pkt_ok),
    .entry_i (entry_in),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      ram_out_q <= 1'b0;
      drop_q    <= 1'b0;
      info_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      ram_out_q <= 1'b0;
      drop_q    <= drop_d;
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            info_q    <= head.info;
            addr_q    <= head.addr;
            data_q    <= head.data;
            ram_out_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (LSUOut_working) begin
            tmo_q   <= '0;
            state_q <= ST_WAIT_DONE;
          end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
            tmo_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!LSUOut_working) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RAM_Out       = ram_out_q;
  assign InfoRamInfo_o = info_q;
  assign InfoRamAddr_o = addr_q;
  assign InfoRamData_o = data_q;
  assign queue_count_o = count;
  assign drop_o        = drop_q;

endmodule

// File: tb/tb_lsu_info_ram_writer.sv
// Directed bench for lsu_info_ram_writer: store/load presentation, queue
// backpressure and ordering, drops, ack timeout, stall and mid-op reset.
module tb_lsu_info_ram_writer;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall_i = 1'b0;
  logic          issue_valid_i = 1'b0;
  logic          issue_ready_o;
  logic [31:0]   issue_mask_i = '0;
  logic [1:0]    issue_warp_i = '0;
  logic [4:0]    issue_reg_i = '0;
  logic [2:0]    issue_op_i = '0;
  logic [1023:0] issue_addr_i = '0;
  logic [1023:0] issue_data_i = '0;
  logic          LSUOut_working;
  logic          RAM_Out;
  logic [41:0]   InfoRamInfo_o;
  logic [1023:0] InfoRamAddr_o;
  logic [1023:0] InfoRamData_o;
  logic [2:0]    queue_count_o;
  logic          drop_o;

  logic man_work = 1'b0;
  logic resp_work = 1'b0;
  logic resp_en = 1'b0;
  int   resp_len = 3;
  int   resp_t = 0;
  assign LSUOut_working = man_work | resp_work;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ram_cnt = 0;
  logic [41:0] cap_info [64];
  int          cap_cyc  [64];

  lsu_info_ram_writer #(.DEPTH(4), .ACK_TIMEOUT(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_mask_i   (issue_mask_i),
    .issue_warp_i   (issue_warp_i),
    .issue_reg_i    (issue_reg_i),
    .issue_op_i     (issue_op_i),
    .issue_addr_i   (issue_addr_i),
    .issue_data_i   (issue_data_i),
    .LSUOut_working (LSUOut_working),
    .RAM_Out        (RAM_Out),
    .InfoRamInfo_o  (InfoRamInfo_o),
    .InfoRamAddr_o  (InfoRamAddr_o),
    .InfoRamData_o  (InfoRamData_o),
    .queue_count_o  (queue_count_o),
    .drop_o         (drop_o)
  );

  always #5 clk = ~clk;

  // Record every presented packet and the cycle it appeared in.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (RAM_Out === 1'b1) begin
      if (ram_cnt < 64) begin
        cap_info[ram_cnt] = InfoRamInfo_o;
        cap_cyc[ram_cnt]  = cyc;
      end
      ram_cnt = ram_cnt + 1;
    end
  end

  // LSUOutUnit stand-in: busy from the cycle after RAM_Out for resp_len cycles.
  always @(posedge clk) begin
    #1;
    if (!resp_en) begin
      resp_t    = 0;
      resp_work = 1'b0;
    end else begin
      if (RAM_Out === 1'b1) resp_t = 1;
      else if (resp_t != 0) resp_t = resp_t + 1;
      if (resp_t > resp_len + 1) resp_t = 0;
      resp_work = (resp_t >= 2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int target, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      samp();
      if (ram_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic set_pkt(input logic [31:0] m, input logic [2:0] o, input logic [1:0] w,
                         input logic [4:0] r, input logic [1023:0] a, input logic [1023:0] d);
    issue_mask_i  = m;
    issue_op_i    = o;
    issue_warp_i  = w;
    issue_reg_i   = r;
    issue_addr_i  = a;
    issue_data_i  = d;
    issue_valid_i = 1'b1;
  endtask

  function automatic int first_diff(input logic [1023:0] x, input logic [1023:0] y);
    for (int k = 0; k < 32; k++)
      if (x[32*k +: 32] !== y[32*k +: 32]) return k;
    return -1;
  endfunction

  logic [1023:0] st_addr, st_data;

  task automatic test_reset();
    #2 reset = 1'b1;
    samp();
    checks++; if (RAM_Out !== 1'b0) begin errors++; $display("FAIL rst_ram_out got %b exp 0", RAM_Out); end
    checks++; if (InfoRamInfo_o !== '0) begin errors++; $display("FAIL rst_info got %h exp 0", InfoRamInfo_o); end
    checks++; if (InfoRamAddr_o !== '0) begin errors++; $display("FAIL rst_addr nonzero slot %0d", first_diff(InfoRamAddr_o, '0)); end
    checks++; if (InfoRamData_o !== '0) begin errors++; $display("FAIL rst_data nonzero slot %0d", first_diff(InfoRamData_o, '0)); end
    checks++; if (queue_count_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", queue_count_o); end
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL rst_drop got %b exp 0", drop_o); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_store();
    bit ok;
    int base;
    for (int k = 0; k < 32; k++) begin
      st_addr[32*k +: 32] = 32'h1000_0000 + 32'(4 * k);
      st_data[32*k +: 32] = 32'(k);
    end
    st_addr[32*31 +: 32] = 32'h0022_CC40;
    resp_en = 1'b1; resp_len = 20;
    base = ram_cnt;
    tick();
    set_pkt(32'h9003_8160, 3'b101, 2'b10, 5'd9, st_addr, st_data);
    tick();
    issue_valid_i = 1'b0;
    wait_pulse(base + 1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL st_pulse timeout got none exp 1"); end
    checks++; if (InfoRamInfo_o !== {32'h9003_8160, 2'b10, 5'b01001, 3'b101}) begin
      errors++; $display("FAIL st_info got %h exp %h", InfoRamInfo_o, {32'h9003_8160, 2'b10, 5'b01001, 3'b101}); end
    checks++; if (InfoRamAddr_o[32*31 +: 32] !== 32'h0022_CC40) begin
      errors++; $display("FAIL st_addr31 got %h exp 0022cc40", InfoRamAddr_o[32*31 +: 32]); end
    checks++; if (InfoRamAddr_o !== st_addr) begin errors++; $display("FAIL st_addr slot %0d got %h", first_diff(InfoRamAddr_o, st_addr), InfoRamAddr_o[32*first_diff(InfoRamAddr_o, st_addr) +: 32]); end
    checks++; if (InfoRamData_o !== st_data) begin errors++; $display("FAIL st_data slot %0d got %h exp slot index", first_diff(InfoRamData_o, st_data), InfoRamData_o[32*first_diff(InfoRamData_o, st_data) +: 32]); end
    samp();
    checks++; if (RAM_Out !== 1'b0) begin errors++; $display("FAIL st_pulse_width got %b exp 0", RAM_Out); end
    for (int i = 0; i < 30; i++) samp();
    checks++; if (ram_cnt !== base + 1) begin errors++; $display("FAIL st_pulse_count got %0d exp %0d", ram_cnt - base, 1); end
    checks++; if (InfoRamInfo_o !== {32'h9003_8160, 2'b10, 5'b01001, 3'b101}) begin
      errors++; $display("FAIL st_hold_info got %h exp %h", InfoRamInfo_o, {32'h9003_8160, 2'b10, 5'b01001, 3'b101}); end
    checks++; if (InfoRamData_o !== st_data) begin errors++; $display("FAIL st_hold_data changed at slot %0d", first_diff(InfoRamData_o, st_data)); end
  endtask

  task automatic test_load();
    bit ok;
    int base;
    logic [1023:0] ones;
    ones = '1;
    base = ram_cnt;
    tick();
    set_pkt(32'h9003_8160, 3'b110, 2'b01, 5'd3, st_addr, ones);
    tick();
    issue_valid_i = 1'b0;
    wait_pulse(base + 1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ld_pulse timeout got none exp 1"); end
    checks++; if (InfoRamData_o !== '0) begin errors++; $display("FAIL ld_data nonzero slot %0d got %h exp 0", first_diff(InfoRamData_o, '0), InfoRamData_o[31:0]); end
    checks++; if (InfoRamInfo_o !== {32'h9003_8160, 2'b01, 5'd3, 3'b110}) begin
      errors++; $display("FAIL ld_info got %h exp %h", InfoRamInfo_o, {32'h9003_8160, 2'b01, 5'd3, 3'b110}); end
    checks++; if (InfoRamAddr_o !== st_addr) begin errors++; $display("FAIL ld_addr slot %0d differs", first_diff(InfoRamAddr_o, st_addr)); end
    for (int i = 0; i < 30; i++) samp();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    logic [41:0] exp_info;
    resp_en = 1'b0;
    man_work = 1'b1;
    base = ram_cnt;
    tick();
    for (int i = 0; i < 5; i++) begin
      set_pkt(32'h1 | (32'h100 << i), 3'b101, 2'(i), 5'(10 + i), st_addr, st_data);
      samp();
      checks++; if (issue_ready_o !== (i < 4)) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", i, issue_ready_o, (i < 4)); end
      tick();
    end
    issue_valid_i = 1'b0;
    samp();
    checks++; if (queue_count_o !== 3'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", queue_count_o); end
    checks++; if (ram_cnt !== base) begin errors++; $display("FAIL b2b_no_out got %0d pulses exp 0", ram_cnt - base); end
    tick();
    man_work = 1'b0;
    resp_en = 1'b1; resp_len = 3;
    wait_pulse(base + 4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain got %0d pulses exp 4", ram_cnt - base); end
    for (int k = 0; k < 4; k++) begin
      exp_info = {32'h1 | (32'h100 << k), 2'(k), 5'(10 + k), 3'b101};
      checks++; if (cap_info[base + k] !== exp_info) begin errors++; $display("FAIL b2b_order[%0d] got %h exp %h", k, cap_info[base + k], exp_info); end
      if (k > 0) begin
        checks++; if (cap_cyc[base + k] - cap_cyc[base + k - 1] != 6) begin
          errors++; $display("FAIL b2b_gap[%0d] got %0d exp 6", k, cap_cyc[base + k] - cap_cyc[base + k - 1]); end
      end
    end
    for (int i = 0; i < 12; i++) samp();
    checks++; if (ram_cnt !== base + 4) begin errors++; $display("FAIL b2b_extra got %0d pulses exp 4", ram_cnt - base); end
    checks++; if (queue_count_o !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", queue_count_o); end
  endtask

  task automatic test_drop();
    int base;
    base = ram_cnt;
    tick();
    set_pkt(32'h0, 3'b101, 2'b00, 5'd1, st_addr, st_data);
    tick();
    issue_valid_i = 1'b0;
    samp();
    checks++; if (drop_o !== 1'b1) begin errors++; $display("FAIL drop_mask0 got %b exp 1", drop_o); end
    checks++; if (queue_count_o !== 3'd0) begin errors++; $display("FAIL drop_mask0_count got %0d exp 0", queue_count_o); end
    samp();
    checks++; if (drop_o !== 1'b0) begin errors++; $display("FAIL drop_once got %b exp 0", drop_o); end
    tick();
    set_pkt(32'hFFFF_FFFF, 3'b011, 2'b00, 5'd2, st_addr, st_data);
    tick();
    issue_valid_i = 1'b0;
    samp();
    checks++; if (drop_o !== 1'b1) begin errors++; $display("FAIL drop_badop got %b exp 1", drop_o); end
    checks++; if (queue_count_o !== 3'd0) begin errors++; $display("FAIL drop_badop_count got %0d exp 0", queue_count_o); end
    for (int i = 0; i < 5; i++) samp();
    checks++; if (ram_cnt !== base) begin errors++; $display("FAIL drop_no_out got %0d pulses exp 0", ram_cnt - base); end
  endtask

  task automatic test_timeout();
    bit ok;
    int base;
    resp_en = 1'b0;
    man_work = 1'b0;
    base = ram_cnt;
    tick();
    set_pkt(32'hF, 3'b101, 2'b11, 5'd20, st_addr, st_data);
    tick();
    set_pkt(32'hF, 3'b110, 2'b11, 5'd21, st_addr, st_data);
    tick();
    issue_valid_i = 1'b0;
    wait_pulse(base + 2, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_second got %0d pulses exp 2", ram_cnt - base); end
    checks++; if (cap_cyc[base + 1] - cap_cyc[base] != 16) begin
      errors++; $display("FAIL tmo_gap got %0d exp 16", cap_cyc[base + 1] - cap_cyc[base]); end
    checks++; if (cap_info[base + 1][7:3] !== 5'd21) begin errors++; $display("FAIL tmo_order got %0d exp 21", cap_info[base + 1][7:3]); end
    for (int i = 0; i < 20; i++) samp();
  endtask

  task automatic test_stall_reset();
    bit ok;
    int base;
    stall_i = 1'b1;
    resp_en = 1'b1; resp_len = 20;
    base = ram_cnt;
    tick();
    set_pkt(32'h3, 3'b101, 2'b00, 5'd24, st_addr, st_data);
    tick();
    set_pkt(32'h3, 3'b101, 2'b00, 5'd25, st_addr, st_data);
    tick();
    issue_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) samp();
    checks++; if (ram_cnt !== base) begin errors++; $display("FAIL stall_no_out got %0d pulses exp 0", ram_cnt - base); end
    checks++; if (queue_count_o !== 3'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", queue_count_o); end
    tick();
    stall_i = 1'b0;
    wait_pulse(base + 1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_release got none exp 1"); end
    for (int i = 0; i < 5; i++) samp();
    #2 reset = 1'b1;
    #1;
    checks++; if (RAM_Out !== 1'b0) begin errors++; $display("FAIL mid_rst_ram_out got %b exp 0", RAM_Out); end
    checks++; if (InfoRamInfo_o !== '0) begin errors++; $display("FAIL mid_rst_info got %h exp 0", InfoRamInfo_o); end
    checks++; if (InfoRamAddr_o !== '0) begin errors++; $display("FAIL mid_rst_addr nonzero slot %0d", first_diff(InfoRamAddr_o, '0)); end
    checks++; if (InfoRamData_o !== '0) begin errors++; $display("FAIL mid_rst_data nonzero slot %0d", first_diff(InfoRamData_o, '0)); end
    checks++; if (queue_count_o !== 3'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", queue_count_o); end
    resp_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) samp();
    checks++; if (ram_cnt !== base + 1) begin errors++; $display("FAIL rst_discard got %0d pulses exp 1", ram_cnt - base); end
    tick();
    set_pkt(32'h5, 3'b110, 2'b01, 5'd26, st_addr, st_data);
    tick();
    issue_valid_i = 1'b0;
    wait_pulse(base + 2, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL post_rst_push got none exp 1"); end
    checks++; if (InfoRamInfo_o !== {32'h5, 2'b01, 5'd26, 3'b110}) begin
      errors++; $display("FAIL post_rst_info got %h exp %h", InfoRamInfo_o, {32'h5, 2'b01, 5'd26, 3'b110}); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_drop();
    test_timeout();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
